// File: rtl/l2_fwd_in_queue.sv
// l2_fwd_in_queue: elastic FWFT queue between the NoC forward-message channel
// and the L2 fwd_in port. Order-preserving, no combinational bypass.
//
// Ports:
//   clk, rst (async, active-low)
//   noc_fwd_*        : NoC-side valid/ready and message fields (coh_msg, addr, req_id)
//   l2_fwd_in_*      : L2-side valid/ready and head-entry fields (coh_msg, addr, req_id)
//   occupancy        : entries currently held
//   peak_occupancy   : sticky maximum occupancy since reset or peak_clr
//   peak_clr         : synchronous clear of peak_occupancy (loads next count)
module l2_fwd_in_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MSG_W  = 3,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned ID_W   = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              noc_fwd_valid,
    output logic              noc_fwd_ready,
    input  logic [MSG_W-1:0]  noc_fwd_data_coh_msg,
    input  logic [ADDR_W-1:0] noc_fwd_data_addr,
    input  logic [ID_W-1:0]   noc_fwd_data_req_id,

    output logic              l2_fwd_in_valid,
    input  logic              l2_fwd_in_ready,
    output logic [MSG_W-1:0]  l2_fwd_in_data_coh_msg,
    output logic [ADDR_W-1:0] l2_fwd_in_data_addr,
    output logic [ID_W-1:0]   l2_fwd_in_data_req_id,

    output logic [CNT_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  peak_occupancy,
    input  logic              peak_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [MSG_W-1:0]  msg_mem  [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [ID_W-1:0]   id_mem   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  peak;
    logic              push;
    logic              pop;

    // Handshakes; ready is held low throughout reset and never looks at the L2 side.
    assign noc_fwd_ready   = rst && (count != CNT_W'(DEPTH));
    assign l2_fwd_in_valid = (count != '0);
    assign push            = noc_fwd_valid && noc_fwd_ready;
    assign pop             = l2_fwd_in_valid && l2_fwd_in_ready;

    // First-word fall-through head.
    assign l2_fwd_in_data_coh_msg = msg_mem[rd_ptr];
    assign l2_fwd_in_data_addr    = addr_mem[rd_ptr];
    assign l2_fwd_in_data_req_id  = id_mem[rd_ptr];

    assign occupancy      = count;
    assign peak_occupancy = peak;

    // Next occupancy; push and pop together leave it unchanged.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and sticky peak.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            if (peak_clr || (count_next > peak)) peak <= count_next;
        end
    end

    // Entry storage; written only on push, left intact on pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                msg_mem[i]  <= '0;
                addr_mem[i] <= '0;
                id_mem[i]   <= '0;
            end
        end else if (push) begin
            msg_mem[wr_ptr]  <= noc_fwd_data_coh_msg;
            addr_mem[wr_ptr] <= noc_fwd_data_addr;
            id_mem[wr_ptr]   <= noc_fwd_data_req_id;
        end
    end

    // Overflow and underflow cannot happen; flag them if they ever do.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(pop && (count == '0)));

endmodule

// File: tb/tb_l2_fwd_in_queue.sv
// Directed self-checking bench for l2_fwd_in_queue.
module tb_l2_fwd_in_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MSG_W  = 3;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              noc_fwd_valid;
    logic              noc_fwd_ready;
    logic [MSG_W-1:0]  noc_fwd_data_coh_msg;
    logic [ADDR_W-1:0] noc_fwd_data_addr;
    logic [ID_W-1:0]   noc_fwd_data_req_id;
    logic              l2_fwd_in_valid;
    logic              l2_fwd_in_ready;
    logic [MSG_W-1:0]  l2_fwd_in_data_coh_msg;
    logic [ADDR_W-1:0] l2_fwd_in_data_addr;
    logic [ID_W-1:0]   l2_fwd_in_data_req_id;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  peak_occupancy;
    logic              peak_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    l2_fwd_in_queue #(
        .DEPTH(DEPTH), .MSG_W(MSG_W), .ADDR_W(ADDR_W), .ID_W(ID_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .noc_fwd_valid          (noc_fwd_valid),
        .noc_fwd_ready          (noc_fwd_ready),
        .noc_fwd_data_coh_msg   (noc_fwd_data_coh_msg),
        .noc_fwd_data_addr      (noc_fwd_data_addr),
        .noc_fwd_data_req_id    (noc_fwd_data_req_id),
        .l2_fwd_in_valid        (l2_fwd_in_valid),
        .l2_fwd_in_ready        (l2_fwd_in_ready),
        .l2_fwd_in_data_coh_msg (l2_fwd_in_data_coh_msg),
        .l2_fwd_in_data_addr    (l2_fwd_in_data_addr),
        .l2_fwd_in_data_req_id  (l2_fwd_in_data_req_id),
        .occupancy              (occupancy),
        .peak_occupancy         (peak_occupancy),
        .peak_clr               (peak_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id);
        noc_fwd_valid        = v;
        noc_fwd_data_addr    = a;
        noc_fwd_data_req_id  = id;
        noc_fwd_data_coh_msg = MSG_W'(id);
    endtask

    initial begin
        rst             = 1'b0;
        l2_fwd_in_ready = 1'b0;
        peak_clr        = 1'b0;
        drive(1'b1, ADDR_W'(32'h55), ID_W'(3));

        // Reset held with valid asserted.
        step(); step();
        check("rst_ready", 32'(noc_fwd_ready), 32'd0);
        check("rst_valid", 32'(l2_fwd_in_valid), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_peak", 32'(peak_occupancy), 32'd0);
        check("rst_addr", 32'(l2_fwd_in_data_addr), 32'd0);
        drive(1'b0, '0, '0);
        rst = 1'b1;
        step();
        check("idle_ready", 32'(noc_fwd_ready), 32'd1);

        // Fill with addrs 0x10..0x13, L2 stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDR_W'(32'h10 + i), ID_W'(i));
            check($sformatf("fill_ready%0d", i), 32'(noc_fwd_ready), 32'd1);
            step();
            if (i == 0) check("first_lat_valid", 32'(l2_fwd_in_valid), 32'd1);
        end
        drive(1'b1, ADDR_W'(32'h99), ID_W'(9));
        check("full_ready", 32'(noc_fwd_ready), 32'd0);
        check("full_occ", 32'(occupancy), 32'd4);
        check("full_peak", 32'(peak_occupancy), 32'd4);
        check("full_head", 32'(l2_fwd_in_data_addr), 32'h10);
        step();
        check("full_hold_occ", 32'(occupancy), 32'd4);
        check("full_hold_head", 32'(l2_fwd_in_data_addr), 32'h10);
        drive(1'b0, '0, '0);

        // Drain in order.
        l2_fwd_in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), 32'(l2_fwd_in_valid), 32'd1);
            check($sformatf("drain_addr%0d", i), 32'(l2_fwd_in_data_addr), 32'h10 + 32'(i));
            step();
        end
        check("empty_valid", 32'(l2_fwd_in_valid), 32'd0);
        check("empty_occ", 32'(occupancy), 32'd0);
        check("empty_peak", 32'(peak_occupancy), 32'd4);

        // Prime count=2 with req_ids 0,1, then stream 20 cycles.
        l2_fwd_in_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ADDR_W'(32'h100 + i), ID_W'(i));
            step();
        end
        l2_fwd_in_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, ADDR_W'(32'h100 + k + 2), ID_W'((k + 2) % 16));
            check($sformatf("strm_id%0d", k), 32'(l2_fwd_in_data_req_id), 32'((k % 16)));
            check($sformatf("strm_occ%0d", k), 32'(occupancy), 32'd2);
            step();
        end
        drive(1'b0, '0, '0);
        l2_fwd_in_ready = 1'b0;
        check("strm_end_id", 32'(l2_fwd_in_data_req_id), 32'd4);
        check("strm_end_addr", 32'(l2_fwd_in_data_addr), 32'h114);
        check("strm_end_occ", 32'(occupancy), 32'd2);

        // Peak clear alone loads current count.
        peak_clr = 1'b1;
        step();
        check("pclr_peak", 32'(peak_occupancy), 32'd2);
        // Peak clear together with an increase loads the new count.
        drive(1'b1, ADDR_W'(32'h200), ID_W'(6));
        step();
        peak_clr = 1'b0;
        check("pclr_inc_peak", 32'(peak_occupancy), 32'd3);
        drive(1'b1, ADDR_W'(32'h201), ID_W'(7));
        step();
        check("refill_occ", 32'(occupancy), 32'd4);

        // Full with valid and ready: pop only, push next cycle.
        drive(1'b1, ADDR_W'(32'h202), ID_W'(8));
        l2_fwd_in_ready = 1'b1;
        step();
        check("fpop_occ", 32'(occupancy), 32'd3);
        check("fpop_head", 32'(l2_fwd_in_data_req_id), 32'd5);
        check("fpop_ready", 32'(noc_fwd_ready), 32'd1);
        l2_fwd_in_ready = 1'b0;
        step();
        check("fpush_occ", 32'(occupancy), 32'd4);
        check("fpush_head", 32'(l2_fwd_in_data_req_id), 32'd5);
        drive(1'b0, '0, '0);
        l2_fwd_in_ready = 1'b1;
        step();
        l2_fwd_in_ready = 1'b0;
        check("pre_rst_occ", 32'(occupancy), 32'd3);

        // Mid-operation reset pulse.
        rst = 1'b0;
        #1;
        check("mrst_occ", 32'(occupancy), 32'd0);
        check("mrst_valid", 32'(l2_fwd_in_valid), 32'd0);
        check("mrst_ready", 32'(noc_fwd_ready), 32'd0);
        check("mrst_peak", 32'(peak_occupancy), 32'd0);
        step();
        rst = 1'b1;
        drive(1'b1, ADDR_W'(32'h2A), ID_W'(1));
        step();
        drive(1'b0, '0, '0);
        check("post_rst_addr", 32'(l2_fwd_in_data_addr), 32'h2A);
        check("post_rst_occ", 32'(occupancy), 32'd1);
        check("post_rst_peak", 32'(peak_occupancy), 32'd1);
        l2_fwd_in_ready = 1'b1;
        step();
        check("post_rst_empty", 32'(l2_fwd_in_valid), 32'd0);
        check("post_rst_peak_hold", 32'(peak_occupancy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
